mem_arbiter: RTL and testbench

Arbiter and sequencer for the single line-wide data memory shared by the instruction cache and the data cache. It accepts line read requests from the iCache and line read or write-back requests from the dCache, and grants one transaction at a time to the memory port. It holds address, data and command stable until the memory signals completion, then returns the line and a one-cycle ready pulse to the granted requester. It sits between both caches and the data memory, in place of the direct dCache-to-memory wiring.

---
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-wide data memory between the iCache and the dCache.
// One transaction is granted at a time. Command, address and write data stay
// stable until memReady. The line then returns with a one-cycle ready pulse.
module mem_arbiter #(
   parameter int LINE_ADDR_W = 30,
   parameter int LINE_W      = 128,
   parameter int TIMEOUT     = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   iRead,
   input  logic [LINE_ADDR_W-1:0] iAddr,
   output logic [LINE_W-1:0]      iLine,
   output logic                   iReady,
   input  logic                   dRead,
   input  logic                   dWrite,
   input  logic [LINE_ADDR_W-1:0] dAddr,
   input  logic [LINE_W-1:0]      dWriteLine,
   output logic [LINE_W-1:0]      dLine,
   output logic                   dReady,
   output logic [LINE_ADDR_W-1:0] memAddr,
   output logic [LINE_W-1:0]      memWriteLine,
   output logic                   memRead,
   output logic                   memWrite,
   input  logic [LINE_W-1:0]      memLine,
   input  logic                   memReady,
   output logic                   memError
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MEM  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic             last_d;     // previous grant went to the dCache
   logic             grant_d;    // current transaction belongs to the dCache
   logic             op_write;   // current transaction is a write-back
   logic             any_req;
   logic             pick_d;
   logic [CNT_W-1:0] wait_cnt;

   // Arbitration: the dCache wins unless it won last time and the iCache is waiting
   always_comb begin
      any_req = iRead | dRead | dWrite;
      pick_d  = (dRead | dWrite) & ~(last_d & iRead);
   end

   // Next-state and command/ready outputs, decoded from the current state
   always_comb begin
      state_next = state;
      memRead    = 1'b0;
      memWrite   = 1'b0;
      iReady     = 1'b0;
      dReady     = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) state_next = MEM;
         end
         MEM: begin
            memRead  = ~op_write;
            memWrite = op_write;
            if (memReady) state_next = RESP;
         end
         RESP: begin
            iReady     = ~grant_d;
            dReady     = grant_d;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Capture the winner, its operation, address and write data at grant time
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_d       <= 1'b0;
         grant_d      <= 1'b0;
         op_write     <= 1'b0;
         memAddr      <= '0;
         memWriteLine <= '0;
      end else if (state == IDLE && any_req) begin
         last_d  <= pick_d;
         grant_d <= pick_d;
         if (pick_d) begin
            // a pending write-back goes ahead of a fill; the fill waits for a later grant
            op_write     <= dWrite;
            memAddr      <= dAddr;
            memWriteLine <= dWriteLine;
         end else begin
            op_write     <= 1'b0;
            memAddr      <= iAddr;
            memWriteLine <= '0;
         end
      end
   end

   // Wait counter and sticky timeout flag; the transaction keeps waiting after timeout
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
         memError <= 1'b0;
      end else if (state == IDLE) begin
         wait_cnt <= '0;
      end else if (state == MEM) begin
         if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + CNT_W'(1);
         if (wait_cnt == CNT_LAST) memError <= 1'b1;
      end
   end

   // Response registers: loaded on read completion, held until the next read
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         iLine <= '0;
         dLine <= '0;
      end else if (state == MEM && memReady && !op_write) begin
         if (grant_d) dLine <= memLine;
         else         iLine <= memLine;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single read, contention alternation,
// write-back then fill, asynchronous reset mid-transaction, timeout, in-flight changes.
module tb_mem_arbiter;

   localparam int AW = 30;
   localparam int LW = 128;

   logic          clk = 1'b0;
   logic          rst;
   logic          iRead;
   logic [AW-1:0] iAddr;
   logic [LW-1:0] iLine;
   logic          iReady;
   logic          dRead;
   logic          dWrite;
   logic [AW-1:0] dAddr;
   logic [LW-1:0] dWriteLine;
   logic [LW-1:0] dLine;
   logic          dReady;
   logic [AW-1:0] memAddr;
   logic [LW-1:0] memWriteLine;
   logic          memRead;
   logic          memWrite;
   logic [LW-1:0] memLine;
   logic          memReady;
   logic          memError;

   int total = 0;
   int bad   = 0;

   mem_arbiter #(.LINE_ADDR_W(AW), .LINE_W(LW), .TIMEOUT(64)) dut (
      .clk(clk), .rst(rst),
      .iRead(iRead), .iAddr(iAddr), .iLine(iLine), .iReady(iReady),
      .dRead(dRead), .dWrite(dWrite), .dAddr(dAddr), .dWriteLine(dWriteLine),
      .dLine(dLine), .dReady(dReady),
      .memAddr(memAddr), .memWriteLine(memWriteLine), .memRead(memRead),
      .memWrite(memWrite), .memLine(memLine), .memReady(memReady),
      .memError(memError)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called in the first MEM cycle; memory completes in cycle 'lat' of MEM.
   task automatic serve(input int lat, input logic [LW-1:0] line);
      for (int c = 1; c < lat; c++) begin
         chk("cmd_held", memRead | memWrite, 1'b1);
         tick();
      end
      chk("cmd_held_last", memRead | memWrite, 1'b1);
      memLine  = line;
      memReady = 1'b1;
      tick();
      memReady = 1'b0;
      memLine  = '0;
   endtask

   task automatic all_zero(input string tag);
      chk({tag, "_iLine"}, iLine, '0);
      chk({tag, "_dLine"}, dLine, '0);
      chk({tag, "_memAddr"}, memAddr, '0);
      chk({tag, "_memWriteLine"}, memWriteLine, '0);
      chk({tag, "_memRead"}, memRead, 1'b0);
      chk({tag, "_memWrite"}, memWrite, 1'b0);
      chk({tag, "_iReady"}, iReady, 1'b0);
      chk({tag, "_dReady"}, dReady, 1'b0);
      chk({tag, "_memError"}, memError, 1'b0);
   endtask

   initial begin
      logic [LW-1:0] lv;
      logic [AW-1:0] exp_addr;
      bit            is_d;

      rst = 1'b1; iRead = 1'b0; iAddr = '0; dRead = 1'b0; dWrite = 1'b0;
      dAddr = '0; dWriteLine = '0; memLine = '0; memReady = 1'b0;
      tick(); tick();
      all_zero("reset");
      rst = 1'b0;
      tick();

      // single iCache read, 5-cycle memory
      iRead = 1'b1; iAddr = 30'h10;
      tick();
      chk("t1_memRead", memRead, 1'b1);
      chk("t1_memWrite", memWrite, 1'b0);
      chk("t1_memAddr", memAddr, 30'h10);
      serve(5, {16{8'hAA}});
      chk("t1_iReady", iReady, 1'b1);
      chk("t1_iLine", iLine, {16{8'hAA}});
      chk("t1_dReady", dReady, 1'b0);
      chk("t1_memRead_resp", memRead, 1'b0);
      iRead = 1'b0;
      tick();
      chk("t1_iReady_idle", iReady, 1'b0);
      chk("t1_iLine_hold", iLine, {16{8'hAA}});
      tick();
      chk("t1_no_regrant", memRead, 1'b0);

      // contention from reset: d, i, d, i, ...
      rst = 1'b1; tick(); rst = 1'b0; tick();
      iRead = 1'b1; iAddr = 30'h4; dRead = 1'b1; dAddr = 30'h8;
      for (int k = 0; k < 8; k++) begin
         is_d     = (k % 2 == 0);
         exp_addr = is_d ? dAddr : 30'h4;
         tick();
         chk("t2_grant_addr", memAddr, exp_addr);
         chk("t2_memRead", memRead, 1'b1);
         lv = {4{32'hC0DE_0000 | 32'(k)}};
         serve(2, lv);
         chk("t2_dReady", dReady, is_d);
         chk("t2_iReady", iReady, !is_d);
         chk("t2_line", is_d ? dLine : iLine, lv);
         if (is_d) dAddr = dAddr + 30'h4;
         tick();
      end
      iRead = 1'b0; dRead = 1'b0;
      tick();

      // write-back and fill together: write first, then the fill
      dWrite = 1'b1; dRead = 1'b1; dAddr = 30'h20; dWriteLine = 128'h1234;
      tick();
      chk("t3_memWrite", memWrite, 1'b1);
      chk("t3_memRead", memRead, 1'b0);
      chk("t3_memWriteLine", memWriteLine, 128'h1234);
      chk("t3_memAddr", memAddr, 30'h20);
      serve(2, 128'hDEAD);
      chk("t3_dReady_wb", dReady, 1'b1);
      dWrite = 1'b0;
      tick();
      chk("t3_idle", memRead | memWrite, 1'b0);
      tick();
      chk("t3_fill_read", memRead, 1'b1);
      chk("t3_fill_write", memWrite, 1'b0);
      chk("t3_fill_addr", memAddr, 30'h20);
      serve(3, {8{16'h5555}});
      chk("t3_dReady_fill", dReady, 1'b1);
      chk("t3_dLine", dLine, {8{16'h5555}});
      dRead = 1'b0;
      tick();

      // asynchronous reset in the middle of MEM
      iRead = 1'b1; iAddr = 30'h30;
      tick();
      chk("t4_memRead", memRead, 1'b1);
      #2 rst = 1'b1; iRead = 1'b0;
      #1 all_zero("t4_async");
      tick();
      rst = 1'b0;
      memLine = {16{8'h99}}; memReady = 1'b1;
      tick();
      memReady = 1'b0; memLine = '0;
      for (int c = 0; c < 3; c++) begin
         chk("t4_iReady_quiet", iReady, 1'b0);
         chk("t4_dReady_quiet", dReady, 1'b0);
         chk("t4_memRead_quiet", memRead, 1'b0);
         tick();
      end

      // timeout: flag after 64 MEM cycles, transaction still completes
      iRead = 1'b1; iAddr = 30'h40;
      tick();
      chk("t5_err_start", memError, 1'b0);
      repeat (63) tick();
      chk("t5_err_before", memError, 1'b0);
      chk("t5_memRead_63", memRead, 1'b1);
      tick();
      chk("t5_err_set", memError, 1'b1);
      chk("t5_memRead_64", memRead, 1'b1);
      serve(1, 128'h77);
      chk("t5_iReady", iReady, 1'b1);
      chk("t5_iLine", iLine, 128'h77);
      iRead = 1'b0;
      tick();
      chk("t5_err_sticky", memError, 1'b1);
      rst = 1'b1; #1;
      chk("t5_err_clear", memError, 1'b0);
      tick(); rst = 1'b0; tick();

      // address and opposing requests changing in flight are ignored
      iRead = 1'b1; iAddr = 30'h50;
      tick();
      iAddr = 30'h60; dWrite = 1'b1; dAddr = 30'h70;
      tick();
      chk("t6_memAddr", memAddr, 30'h50);
      chk("t6_memWrite", memWrite, 1'b0);
      serve(2, 128'hBEEF);
      chk("t6_iReady", iReady, 1'b1);
      chk("t6_dReady", dReady, 1'b0);
      chk("t6_iLine", iLine, 128'hBEEF);
      iRead = 1'b0; dWrite = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
